// File: rtl/chipset_mapper.sv
`default_nettype none
// ============================================================================
// Module      : chipset_mapper
// Description : Bank-window address mapper and wait-state generator for the
//               chipset I/O block.
//               - NUM_WINDOWS consecutive 64 KB windows starting at WIN_BASE
//                 remap CPU addresses into a PHYS_ADDR_W-bit physical space.
//               - An 8-byte register block at IO_BASE holds the bank registers,
//                 the wait-state register and the control register.
//               - A three-state wait FSM drives CPU READY.
// Ports       :
//   clk      in   system clock; all bus inputs are synchronous to it
//   RESET_N  in   asynchronous active-low reset
//   ALE      in   address latch enable; samples the translation
//   M_IO     in   1 = memory cycle, 0 = I/O cycle
//   RD_N     in   read strobe, active low
//   WR_N     in   write strobe, active low
//   ADDR     in   latched CPU address (20 bits)
//   DATA_IN  in   CPU write data, low byte
//   DATA_OUT out  registered register-read data
//   DATA_OE  out  high while DATA_OUT must drive the bus
//   RDY_EXT  in   external ready from slow peripherals
//   READY    out  CPU ready
//   PADDR    out  physical address (PHYS_ADDR_W bits)
//   MAP_HIT  out  latched memory cycle falls in an enabled window
// Revision    : 1.0 - initial release
// ============================================================================
module chipset_mapper #(
    parameter int           NUM_WINDOWS = 2,
    parameter logic [3:0]   WIN_BASE    = 4'h8,
    parameter int           BANK_BITS   = 5,
    parameter logic [9:0]   IO_BASE     = 10'h030,
    localparam int          PHYS_ADDR_W = BANK_BITS + 17
) (
    input  logic                   clk,
    input  logic                   RESET_N,
    input  logic                   ALE,
    input  logic                   M_IO,
    input  logic                   RD_N,
    input  logic                   WR_N,
    input  logic [19:0]            ADDR,
    input  logic [7:0]             DATA_IN,
    output logic [7:0]             DATA_OUT,
    output logic                   DATA_OE,
    input  logic                   RDY_EXT,
    output logic                   READY,
    output logic [PHYS_ADDR_W-1:0] PADDR,
    output logic                   MAP_HIT
);

    localparam logic [2:0] c_off_wait = 3'd6;
    localparam logic [2:0] c_off_ctrl = 3'd7;
    localparam logic [7:0] c_wait_rst = 8'h33;
    localparam logic [7:0] c_wait_msk = 8'h77;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [BANK_BITS-1:0] r_bank [NUM_WINDOWS];
    logic [7:0]           r_wait;
    logic                 r_ctrl_en;

    // Write capture: data is latched while WR_N is low and committed when
    // the registered strobe sees its rising edge.
    logic                 r_wr_n_q;
    logic                 r_wr_pend;
    logic [2:0]           r_wr_off;
    logic [7:0]           r_wr_data;

    logic                 w_io_match;
    logic                 w_wr_commit;
    logic [7:0]           w_rd_data;

    assign w_io_match  = !M_IO && (ADDR[9:3] == IO_BASE[9:3]);
    assign w_wr_commit = r_wr_pend && !r_wr_n_q && WR_N;
    assign DATA_OE     = !RD_N && w_io_match;

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_n_q  <= 1'b1;
            r_wr_pend <= 1'b0;
            r_wr_off  <= 3'd0;
            r_wr_data <= 8'h00;
        end else begin
            r_wr_n_q <= WR_N;
            if (!WR_N && w_io_match) begin
                r_wr_pend <= 1'b1;
                r_wr_off  <= ADDR[2:0];
                r_wr_data <= DATA_IN;
            end else if (w_wr_commit) begin
                r_wr_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_WINDOWS; i++) begin
                r_bank[i] <= BANK_BITS'(i);
            end
            r_wait    <= c_wait_rst;
            r_ctrl_en <= 1'b0;
        end else if (w_wr_commit) begin
            for (int i = 0; i < NUM_WINDOWS; i++) begin
                if (r_wr_off == 3'(i)) begin
                    r_bank[i] <= r_wr_data[BANK_BITS-1:0];
                end
            end
            if (r_wr_off == c_off_wait) begin
                r_wait <= r_wr_data & c_wait_msk;
            end
            if (r_wr_off == c_off_ctrl) begin
                r_ctrl_en <= r_wr_data[0];
            end
        end
    end

    // Read mux; unimplemented offsets and unused bits return zero.
    always_comb begin
        w_rd_data = 8'h00;
        for (int i = 0; i < NUM_WINDOWS; i++) begin
            if (ADDR[2:0] == 3'(i)) begin
                w_rd_data = 8'(r_bank[i]);
            end
        end
        if (ADDR[2:0] == c_off_wait) begin
            w_rd_data = r_wait;
        end
        if (ADDR[2:0] == c_off_ctrl) begin
            w_rd_data = {7'b0, r_ctrl_en};
        end
        if (!w_io_match) begin
            w_rd_data = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            DATA_OUT <= 8'h00;
        end else begin
            DATA_OUT <= w_rd_data;
        end
    end

    // ------------------------------------------------------------------
    // Address translation
    // ------------------------------------------------------------------
    // The window offset is computed one bit wider so that addresses below
    // WIN_BASE wrap to a large value and fail the range compare.
    logic [4:0]           w_win_off;
    logic                 w_win_hit;
    logic [BANK_BITS-1:0] w_bank_sel;

    assign w_win_off = {1'b0, ADDR[19:16]} - {1'b0, WIN_BASE};
    assign w_win_hit = M_IO && r_ctrl_en && (w_win_off < 5'(NUM_WINDOWS));

    always_comb begin
        w_bank_sel = '0;
        for (int i = 0; i < NUM_WINDOWS; i++) begin
            if (w_win_off == 5'(i)) begin
                w_bank_sel = r_bank[i];
            end
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            PADDR   <= '0;
            MAP_HIT <= 1'b0;
        end else if (ALE) begin
            if (w_win_hit) begin
                PADDR   <= {1'b1, w_bank_sel, ADDR[15:0]};
                MAP_HIT <= 1'b1;
            end else begin
                PADDR   <= PHYS_ADDR_W'(ADDR);
                MAP_HIT <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Wait-state FSM
    // ------------------------------------------------------------------
    // The strobe-assertion clock already counts as the first wait, so the
    // counter is loaded with N-1 and WAIT lasts N-1 clocks: READY is low
    // for exactly N clocks in total.
    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic [2:0] w_load;
    logic       w_strobe;
    logic       w_ready;

    assign w_strobe = !RD_N || !WR_N;
    assign w_load   = M_IO ? r_wait[2:0] : r_wait[6:4];

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready     = RDY_EXT;
        case (r_state)
            ST_IDLE: begin
                if (w_strobe) begin
                    if (w_load == 3'd0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_ready     = 1'b0;
                        w_cnt_nxt   = w_load - 3'd1;
                        w_state_nxt = (w_load == 3'd1) ? ST_DONE : ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_ready = 1'b0;
                if (!w_strobe) begin
                    // Aborted cycle: release READY on the next clock.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!w_strobe) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // READY is forced high while reset is asserted, even if a strobe is
    // still active on the bus.
    assign READY = !RESET_N || w_ready;

endmodule
`default_nettype wire

// File: tb/tb_chipset_mapper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_chipset_mapper
// Description : Self-checking bench for chipset_mapper with a behavioural
//               register/translation/wait model and randomized bus traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chipset_mapper;

    localparam int         NW  = 2;
    localparam logic [3:0] WB  = 4'h8;
    localparam int         BB  = 5;
    localparam logic [9:0] IOB = 10'h030;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ale;
    logic        m_io;
    logic        rd_n;
    logic        wr_n;
    logic [19:0] addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        rdy_ext;
    logic        ready;
    logic [BB+16:0] paddr;
    logic        map_hit;

    always #5 clk = ~clk;

    chipset_mapper #(
        .NUM_WINDOWS (NW),
        .WIN_BASE    (WB),
        .BANK_BITS   (BB),
        .IO_BASE     (IOB)
    ) dut (
        .clk      (clk),
        .RESET_N  (rst_n),
        .ALE      (ale),
        .M_IO     (m_io),
        .RD_N     (rd_n),
        .WR_N     (wr_n),
        .ADDR     (addr),
        .DATA_IN  (data_in),
        .DATA_OUT (data_out),
        .DATA_OE  (data_oe),
        .RDY_EXT  (rdy_ext),
        .READY    (ready),
        .PADDR    (paddr),
        .MAP_HIT  (map_hit)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int   m_bank [NW];
    int   m_wait;
    bit   m_en;

    function automatic void model_reset();
        for (int i = 0; i < NW; i++) m_bank[i] = i;
        m_wait = 'h33;
        m_en   = 1'b0;
    endfunction

    function automatic void model_write(input int off, input int d);
        if (off < NW)       m_bank[off] = d % (1 << BB);
        else if (off == 6)  m_wait = d & 'h77;
        else if (off == 7)  m_en = d[0];
    endfunction

    function automatic int model_read(input int off);
        if (off < NW)  return m_bank[off];
        if (off == 6)  return m_wait;
        if (off == 7)  return int'(m_en);
        return 0;
    endfunction

    function automatic bit model_hit(input logic [19:0] a, input logic mio);
        int hi;
        hi = int'(a[19:16]);
        return mio && m_en && (hi >= int'(WB)) && (hi < int'(WB) + NW);
    endfunction

    function automatic logic [31:0] model_paddr(input logic [19:0] a, input logic mio);
        if (model_hit(a, mio))
            return (32'd1 << (BB + 16)) + 32'(m_bank[int'(a[19:16]) - int'(WB)]) * 65536 + 32'(a[15:0]);
        return 32'(a);
    endfunction

    function automatic int model_waits(input logic mio);
        return mio ? (m_wait & 7) : ((m_wait >> 4) & 7);
    endfunction

    // ------------------------------------------------------------------
    // Bus tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic io_write(input logic [19:0] a, input logic [7:0] d);
        m_io = 1'b0; addr = a; data_in = d; wr_n = 1'b0;
        tick(); tick();
        wr_n = 1'b1;
        tick(); tick(); tick();
        if (a[9:3] == IOB[9:3]) model_write(int'(a[2:0]), int'(d));
    endtask

    task automatic io_read(input logic [19:0] a);
        bit match;
        match = (a[9:3] == IOB[9:3]);
        m_io = 1'b0; addr = a; rd_n = 1'b0;
        #1;
        check_eq("data_oe", 32'(data_oe), 32'(match));
        tick();
        if (match) check_eq("rd_data", 32'(data_out), 32'(model_read(int'(a[2:0]))));
        rd_n = 1'b1;
        tick(); tick();
    endtask

    task automatic mem_ale(input logic [19:0] a, input logic mio);
        logic [31:0] exp_pa;
        bit          exp_hit;
        exp_pa  = model_paddr(a, mio);
        exp_hit = model_hit(a, mio);
        m_io = mio; addr = a; ale = 1'b1;
        tick();
        ale = 1'b0;
        addr = 20'($urandom);      // translation must hold until next ALE
        tick();
        check_eq("paddr", 32'(paddr), exp_pa);
        check_eq("map_hit", 32'(map_hit), 32'(exp_hit));
    endtask

    // Runs one strobe with RDY_EXT held low for the first e clocks and counts
    // the clocks READY stays low; expected is the larger of the two delays.
    task automatic bus_wait(input logic mio, input bit use_rd, input int e);
        int lows;
        int exp;
        exp  = model_waits(mio);
        if (e > exp) exp = e;
        m_io = mio;
        addr = mio ? 20'h12345 : 20'h00100;
        if (use_rd) rd_n = 1'b0; else wr_n = 1'b0;
        rdy_ext = (e == 0);
        lows = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (ready) break;
            lows++;
            tick();
            if (lows >= e) rdy_ext = 1'b1;
        end
        check_eq("wait_clks", 32'(lows), 32'(exp));
        rd_n = 1'b1; wr_n = 1'b1; rdy_ext = 1'b1;
        tick(); tick();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; ale = 1'b0; m_io = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        addr = 20'h0; data_in = 8'h0; rdy_ext = 1'b1;
        model_reset();
        #12;
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_paddr", 32'(paddr), 32'd0);
        check_eq("rst_hit", 32'(map_hit), 32'd0);
        check_eq("rst_dout", 32'(data_out), 32'd0);
        check_eq("rst_oe", 32'(data_oe), 32'd0);
        rst_n = 1'b1;
        tick();

        // Reset register values
        io_read(20'h00030); io_read(20'h00031); io_read(20'h00036); io_read(20'h00037);

        // Passthrough with map disabled; default memory waits of three
        mem_ale(20'h81234, 1'b1);
        check_eq("tp_pass", 32'(paddr), 32'h081234);
        bus_wait(1'b1, 1'b1, 0);

        // Enable map, bank 1 = 0x1A
        io_write(20'h00037, 8'h01);
        io_write(20'h00031, 8'h1A);
        mem_ale(20'h9ABCD, 1'b1);
        check_eq("tp_map", 32'(paddr), 32'h3AABCD);
        mem_ale(20'hA0000, 1'b1);
        mem_ale(20'h7FFFF, 1'b1);
        mem_ale(20'h80001, 1'b0);

        // Zero memory waits, I/O waits 7
        io_write(20'h00036, 8'h70);
        bus_wait(1'b1, 1'b1, 0);
        io_read(20'h00036);
        bus_wait(1'b0, 1'b0, 0);

        // Bank width masking, unused offsets
        io_write(20'h00030, 8'hFF);
        io_read(20'h00030);
        check_eq("tp_mask", 32'(data_out), 32'h1F);
        io_read(20'h00034);
        io_write(20'h00035, 8'h55);
        io_read(20'h00035);
        io_write(20'h00038, 8'h00);           // outside the block: ignored
        io_read(20'h00037);

        // Abort mid-WAIT with five memory waits
        io_write(20'h00036, 8'h05);
        m_io = 1'b1; rd_n = 1'b0;
        tick(); tick();
        check_eq("abort_wait", 32'(ready), 32'd0);
        rd_n = 1'b1;
        tick();
        check_eq("abort_ready", 32'(ready), 32'd1);
        tick();
        bus_wait(1'b1, 1'b1, 0);
        bus_wait(1'b1, 1'b0, 7);

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            int op;
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    logic [19:0] a;
                    a = {10'($urandom), ($urandom_range(0, 7) == 0) ? 7'h07 : IOB[9:3], 3'($urandom_range(0, 7))};
                    io_write(a, 8'($urandom));
                end
                1: begin
                    logic [19:0] a;
                    a = {10'($urandom), ($urandom_range(0, 7) == 0) ? 7'h05 : IOB[9:3], 3'($urandom_range(0, 7))};
                    io_read(a);
                end
                2: begin
                    logic [19:0] a;
                    a = {4'($urandom_range(6, 11)), 16'($urandom)};
                    mem_ale(a, ($urandom_range(0, 4) != 0));
                end
                default: bus_wait(1'($urandom), 1'($urandom), $urandom_range(0, 6));
            endcase
        end

        // Asynchronous reset in the middle of a wait
        io_write(20'h00037, 8'h01);
        io_write(20'h00036, 8'h07);
        mem_ale(20'h81111, 1'b1);
        m_io = 1'b1; rd_n = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check_eq("arst_ready", 32'(ready), 32'd1);
        check_eq("arst_paddr", 32'(paddr), 32'd0);
        check_eq("arst_hit", 32'(map_hit), 32'd0);
        rd_n = 1'b1;
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        io_read(20'h00030); io_read(20'h00031); io_read(20'h00036); io_read(20'h00037);
        mem_ale(20'h81234, 1'b1);
        bus_wait(1'b1, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chipset_mapper.md
Name: chipset_mapper

Overview:
- Parametrised successor to the single-bank chipset register and fixed-timing glue.
- Provides NUM_WINDOWS independently programmable 64 KB bank windows that remap CPU addresses into a wider physical address space.
- Provides an I/O-programmable wait-state generator that drives CPU READY.
- Sits between the latched CPU bus (ADDR/M_IO/RD_N/WR_N) and the RAM/ROM decode logic.
- Mapper registers sit in the chipset I/O block at IO_BASE.

Parameters:
NUM_WINDOWS, 2, number of consecutive 64 KB bank windows (1..4)
WIN_BASE, 4'h8, ADDR[19:16] of the first window; window i covers addr_hi == WIN_BASE+i
BANK_BITS, 5, bank register width (4..6); localparam PHYS_ADDR_W = BANK_BITS+17
IO_BASE, 10'h030, base of the 8-byte register block; ADDR[9:3] must match IO_BASE[9:3]

Ports:
clk  in  1  system clock; all bus inputs are synchronous to it
RESET_N  in  1  asynchronous active-low reset
ALE  in  1  address latch enable, active high
M_IO  in  1  1 = memory cycle, 0 = I/O cycle
RD_N  in  1  read strobe, active low
WR_N  in  1  write strobe, active low
ADDR  in  20  latched CPU address
DATA_IN  in  8  CPU write data, low byte
DATA_OUT  out  8  register read data
DATA_OE  out  1  high while DATA_OUT must drive the bus
RDY_EXT  in  1  external ready from slow peripherals, active high
READY  out  1  CPU ready, active high
PADDR  out  PHYS_ADDR_W  physical address
MAP_HIT  out  1  current memory cycle falls in an enabled window

Behaviour:
- Reset (RESET_N low, async) values:
  - bank_reg[i] = i.
  - wait_reg = 8'h33.
  - ctrl_reg = 8'h00.
  - READY = 1, PADDR = 0, MAP_HIT = 0, DATA_OUT = 0, DATA_OE = 0.
  - Wait counter = 0. Write-edge detector primed with WR_N = 1.
- Register map (offset = ADDR[2:0], I/O cycles only):
  - 0..NUM_WINDOWS-1: bank_reg[offset], R/W; only the low BANK_BITS bits are stored, unused bits read 0.
  - 6: wait_reg, R/W. Bits [2:0] are memory waits, bits [6:4] are I/O waits; bits 7 and 3 read 0.
  - 7: ctrl_reg, R/W. Bit 0 = map enable; all other bits read 0.
  - Other offsets: writes are ignored, reads return 8'h00.
- Register write:
  - Latch DATA_IN every clk in which WR_N = 0 and the I/O address matches.
  - Commit the latched value on the clk where the registered WR_N goes 0→1.
  - The write therefore takes effect one clk after WR_N deasserts.
- Register read:
  - DATA_OE = 1 combinationally while RD_N = 0, M_IO = 0 and the address matches.
  - DATA_OUT is the registered value, updated every clk.
- Address translation (registered, sampled on clk where ALE = 1):
  - Condition: M_IO = 1, ctrl_reg[0] = 1 and WIN_BASE <= addr_hi < WIN_BASE+NUM_WINDOWS.
  - When true: PADDR = {1'b1, bank_reg[addr_hi-WIN_BASE], ADDR[15:0]}, MAP_HIT = 1.
  - Otherwise: PADDR = zero-extended ADDR, MAP_HIT = 0.
  - PADDR and MAP_HIT hold until the next ALE.
  - A bank write completing during a bus cycle affects only the next ALE.
- Wait-state FSM, states IDLE / WAIT / DONE:
  - IDLE: on the first clk with RD_N = 0 or WR_N = 0, load cnt with wait_reg[2:0] (M_IO = 1) or wait_reg[6:4] (M_IO = 0). Go to WAIT if the loaded count is nonzero, else DONE.
  - WAIT: cnt decrements each clk; go to DONE when cnt reaches 1→0.
  - DONE: stay until RD_N and WR_N are both 1, then go to IDLE.
  - READY = 0 in WAIT and the loading clk when count > 0; READY = RDY_EXT in IDLE/DONE. RDY_EXT = 0 extends any cycle.
  - Strobe deassertion mid-WAIT (abort): return to IDLE and set READY = 1 next clk.
  - Reset mid-cycle: return to IDLE, READY = 1 immediately.

Test Plan:
- Reset with no writes; ALE with ADDR=20'h81234, M_IO=1 -> PADDR=22'h081234, MAP_HIT=0; mem read with RDY_EXT=1 -> READY low 3 clks, then high.
- I/O write 8'h01 to 0x037, 8'h1A to 0x031; memory ALE ADDR=20'h9ABCD -> PADDR=22'h3AABCD, MAP_HIT=1; ADDR=20'hA0000 -> passthrough, MAP_HIT=0.
- Write 8'h70 to 0x036; mem read -> READY never drops; I/O read of 0x036 -> DATA_OE=1, DATA_OUT=8'h70.
- Write 8'hFF to 0x030 -> readback 8'h1F; read 0x034 -> 8'h00; write to 0x035 ignored.
- Set mem waits=5, assert RD_N, deassert RD_N after 2 clks -> FSM IDLE, READY=1 next clk; next cycle waits the full 5.
- Pulse RESET_N low mid-WAIT -> READY=1, PADDR=0, all registers at reset values asynchronously.
